// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: MSB-first 1:8 deserializer, comma-aligned, with a SEARCH/COUNT/ACTIVE lock FSM.
// Define SP_RESYNC_EN to realign on off-boundary commas seen while ACTIVE.
module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned LOCK_COMMAS = 4
) (
  input  logic       clk16f,
  input  logic       reset_L,
  input  logic       serial_in,
  output logic [8:0] paralelo_out,
  output logic       paralelo_strobe,
  output logic       active
);
  typedef enum logic [1:0] {SEARCH, COUNT, ACTIVE} state_t;
  localparam state_t     FIRST_ST = (LOCK_COMMAS == 1) ? ACTIVE : COUNT;
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COMMAS);
  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [8:0] out_q, out_d;
  logic       strobe_q, strobe_d;
  logic       active_q;
  logic       is_comma, boundary;
  always_comb begin
    sr_d        = {sr_q[6:0], serial_in};
    is_comma    = sr_d == COMMA;
    boundary    = bit_cnt_q == 3'd7;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    out_d       = out_q;
    strobe_d    = 1'b0;
    case (state_q)
      SEARCH: begin
        bit_cnt_d = bit_cnt_q;
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          state_d     = FIRST_ST;
        end
      end
      COUNT: begin
        if (boundary && is_comma) begin
          comma_cnt_d = comma_cnt_q + 4'd1;
          state_d     = (comma_cnt_d == LOCK_N) ? ACTIVE : COUNT;
        end else if (boundary) begin
          comma_cnt_d = 4'd0;
          state_d     = SEARCH;
        end
      end
      default: begin
        if (boundary) begin
          strobe_d = 1'b1;
          out_d    = is_comma ? {1'b0, COMMA} : {1'b1, sr_d};
        end
`ifdef SP_RESYNC_EN
        // A comma off the boundary means we slipped: drop the partial word and relock on it.
        else if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          state_d     = FIRST_ST;
        end
`endif
      end
    endcase
  end
  always_ff @(posedge clk16f) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      out_q       <= 9'h000;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      out_q       <= out_d;
      strobe_q    <= strobe_d;
      active_q    <= state_d == ACTIVE;
    end
  end
  assign paralelo_out    = out_q;
  assign paralelo_strobe = strobe_q;
  assign active          = active_q;
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: directed plan plus random stream, checked every cycle against a bit-index alignment model.
module tb_serial_paralelo_rx;
  localparam logic [7:0] BC   = 8'hBC;
  localparam int         LOCK = 4;
  logic       clk16f = 1'b0, reset_L = 1'b0, serial_in = 1'b0;
  logic [8:0] paralelo_out;
  logic       paralelo_strobe, active;
  int tests = 0, fails = 0, cyc = 0;
  serial_paralelo_rx #(.COMMA(BC), .LOCK_COMMAS(LOCK)) dut (
    .clk16f(clk16f), .reset_L(reset_L), .serial_in(serial_in),
    .paralelo_out(paralelo_out), .paralelo_strobe(paralelo_strobe), .active(active)
  );
  always #5 clk16f = ~clk16f;
  // Model: alignment is an anchor bit index; boundaries are bits a multiple of 8 after it.
  logic [7:0] win;
  logic [8:0] m_out;
  logic       m_stb;
  int t, anchor, n, mode;
  bit started = 0, on_b;
  logic [8:0] log_v[$];
  int         log_c[$];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  always @(posedge clk16f) begin
    if (!reset_L) begin
      started = 1; win = 0; t = 0; anchor = 0; n = 0; mode = 0; m_out = 0; m_stb = 0;
    end else if (started) begin
      win = {win[6:0], serial_in};
      t++;
      on_b = mode != 0 && ((t - anchor) % 8 == 0);
      m_stb = 0;
      if (mode == 0) begin
        if (win == BC) begin anchor = t; n = 1; mode = (LOCK == 1) ? 2 : 1; end
      end else if (mode == 1) begin
        if (on_b && win == BC) begin n++; if (n == LOCK) mode = 2; end
        else if (on_b) begin n = 0; mode = 0; end
      end else begin
        if (on_b) begin m_stb = 1; m_out = (win == BC) ? {1'b0, BC} : {1'b1, win}; end
`ifdef SP_RESYNC_EN
        else if (win == BC) begin anchor = t; n = 1; mode = (LOCK == 1) ? 2 : 1; end
`endif
      end
    end
  end
  always @(negedge clk16f) begin
    cyc++;
    if (started) begin
      chk("cyc paralelo_out", 32'(paralelo_out), 32'(m_out));
      chk("cyc strobe", 32'(paralelo_strobe), 32'(m_stb));
      chk("cyc active", 32'(active), 32'(mode == 2));
      if (paralelo_strobe) begin log_v.push_back(paralelo_out); log_c.push_back(cyc); end
    end
  end
  task automatic send_bit(logic b);
    serial_in = b;
    @(negedge clk16f);
  endtask
  task automatic send_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic do_reset();
    reset_L = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    reset_L = 1'b1;
  endtask
  initial begin
    // 1: reset with toggling input
    do_reset();
    #1;
    chk("reset out", 32'(paralelo_out), 32'h000);
    chk("reset strobe", 32'(paralelo_strobe), 0);
    chk("reset active", 32'(active), 0);
    chk("model reset out", 32'(m_out), 32'h000);
    // 2: junk then four commas
    log_v.delete(); log_c.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(BC);
    for (int i = 7; i >= 1; i--) send_bit(BC[i]);
    #1;
    chk("lock active before last bit", 32'(active), 0);
    send_bit(BC[0]);
    #1;
    chk("lock active", 32'(active), 1);
    chk("model lock mode", 32'(mode), 2);
    chk("lock no strobes", 32'(log_v.size()), 0);
    // 3: data words
    send_byte(8'hFF); send_byte(8'h55); send_byte(8'h00); send_byte(BC); send_byte(8'hF0);
    send_byte(BC);
    #1;
    chk("data count", 32'(log_v.size()), 6);
    for (int i = 0; i < 5 && i < log_v.size(); i++) begin
      chk("data word", 32'(log_v[i]), (i == 0) ? 32'h1FF : (i == 1) ? 32'h155 : (i == 2) ? 32'h100 : (i == 3) ? 32'h0BC : 32'h1F0);
      if (i > 0) chk("data spacing", 32'(log_c[i] - log_c[i-1]), 8);
    end
    // 5: reset at bit 3 of a word
    log_v.delete(); log_c.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset_L = 1'b0;
    send_bit(1'b1);
    #1;
    chk("midreset active", 32'(active), 0);
    chk("midreset out", 32'(paralelo_out), 32'h000);
    chk("midreset no strobe", 32'(log_v.size()), 0);
    reset_L = 1'b1;
    // 4: failed lock then lock
    send_byte(BC); send_byte(BC); send_byte(8'h55);
    #1;
    chk("failed lock active", 32'(active), 0);
    chk("model failed lock mode", 32'(mode), 0);
    for (int i = 0; i < 4; i++) send_byte(BC);
    #1;
    chk("relock active", 32'(active), 1);
    chk("relock no strobes", 32'(log_v.size()), 0);
    // 6: one-bit slip while ACTIVE
    log_v.delete(); log_c.delete();
    send_bit(1'b0);
    send_byte(BC);
    #1;
`ifdef SP_RESYNC_EN
    chk("slip active drop", 32'(active), 0);
    send_byte(BC); send_byte(BC);
    #1;
    chk("slip active before relock", 32'(active), 0);
    send_byte(BC);
    #1;
    chk("slip relock", 32'(active), 1);
    send_byte(8'h55); send_byte(BC);
    #1;
    chk("slip count", 32'(log_v.size()), 3);
    if (log_v.size() > 1) chk("slip 55 word", 32'(log_v[1]), 32'h155);
`else
    chk("slip active held", 32'(active), 1);
    for (int i = 0; i < 3; i++) send_byte(BC);
    send_byte(8'h55); send_byte(BC);
    #1;
    chk("slip active still", 32'(active), 1);
    chk("slip count", 32'(log_v.size()), 6);
    for (int i = 0; i < log_v.size(); i++) chk("slip valid bit", 32'(log_v[i][8]), 1);
    if (log_v.size() > 4) chk("slip shifted word", 32'(log_v[4]), 32'h12A);
`endif
    // random stream: comma-heavy bytes, bit slips, occasional resets
    for (int k = 0; k < 400; k++) begin
      automatic int r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 8) send_bit(1'($urandom));
      else send_byte((r < 50) ? BC : 8'($urandom));
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive-side counterpart of the lane's parallel-to-serial transmitter. Deserializes a 1-bit serial stream, MSB first, into 9-bit words {valid, data[7:0]}. Aligns word boundaries on the COMMA idle symbol (K28.5 payload 8'hBC). Declares the lane active after LOCK_COMMAS consecutive aligned commas. Sits between the serial lane and the parallel-side logic, running in the serial bit-clock domain.

Parameters:
COMMA, 8'hBC, idle/alignment symbol the transmitter sends when its input is invalid
LOCK_COMMAS, 4, consecutive aligned commas required to enter ACTIVE (range 1..15)

Ports:
clk16f  input  1  serial bit clock; one serial bit is sampled per rising edge
reset_L  input  1  synchronous, active-low reset, sampled on clk16f
serial_in  input  1  serial data bit, MSB of each byte first
paralelo_out  output  9  registered word: bit 8 = valid, bits 7:0 = data
paralelo_strobe  output  1  one-cycle pulse; paralelo_out is updated in the same cycle
active  output  1  1 while the state machine is in ACTIVE

Behaviour:
- Reset: reset_L=0 at a rising edge gives paralelo_out=9'h000, paralelo_strobe=0, active=0, state=SEARCH, shift register=0, bit_cnt=0, comma_cnt=0. Reset in mid-operation behaves the same way; no partial word is emitted.
- Shift register sr[7:0]. sr_next = {sr[6:0], serial_in} is updated every cycle. All comparisons use sr_next.
- bit_cnt is 3 bits wide. A word boundary is the cycle in which bit_cnt==7. bit_cnt wraps 7->0.
- SEARCH: bit_cnt is ignored. If sr_next==COMMA: bit_cnt<=0, comma_cnt<=1, and the state goes to COUNT. If LOCK_COMMAS==1, the state goes directly to ACTIVE instead.
- COUNT: bit_cnt increments each cycle. At a word boundary:
  - If sr_next==COMMA, comma_cnt increments. When it reaches LOCK_COMMAS, the state goes to ACTIVE.
  - Otherwise comma_cnt<=0 and the state returns to SEARCH.
  - No strobes are produced in COUNT.
- ACTIVE: bit_cnt increments each cycle. At each word boundary, in the next cycle, paralelo_strobe=1 and:
  - paralelo_out = {1'b0, COMMA} if sr_next==COMMA;
  - paralelo_out = {1'b1, sr_next} otherwise.
- Latency and output timing:
  - Latency is 1 clk16f cycle from sampling the 8th bit to paralelo_out/strobe.
  - Strobe spacing is exactly 8 cycles.
  - paralelo_out holds its value between strobes.
- active rises in the cycle after the boundary at which the LOCK_COMMAS-th comma completes. It is registered, with the same timing as paralelo_strobe. The lock-completing comma is not emitted.
- ACTIVE is left only by reset, or by the optional resync path below.
- A comma appearing off-boundary in SEARCH/COUNT: SEARCH handles it as above. COUNT ignores it.

Optional Feature:
SP_RESYNC_EN.
- Defined: in ACTIVE, if sr_next==COMMA and bit_cnt!=7, then:
  - bit_cnt<=0, comma_cnt<=1, state<=COUNT, active<=0;
  - the partial word is discarded and no strobe is produced;
  - relock requires LOCK_COMMAS-1 further aligned commas.
- Undefined: off-boundary commas in ACTIVE are ignored, and misaligned words continue to be emitted with valid=1.

Test Plan:
1. Reset: reset_L=0 for 2 edges while serial_in toggles -> paralelo_out=9'h000, paralelo_strobe=0, active=0 throughout.
2. Lock: reset_L=1, 3 junk bits (1,0,1), then four 8'hBC -> active=1 one cycle after the 32nd comma bit; no strobes before that.
3. Data: after lock send 8'hFF, 8'h55, 8'h00, 8'hBC, 8'hF0 -> strobes 8 cycles apart with paralelo_out 9'h1FF, 9'h155, 9'h100, 9'h0BC, 9'h1F0.
4. Failed lock: send BC, BC, 8'h55, then BC×4 -> return to SEARCH after 8'h55, active=0; lock after the final four commas.
5. Reset mid-ACTIVE: reset_L=0 at bit 3 of a word -> on the next edge active=0 and paralelo_out=9'h000; no strobe for the partial word.
6. Bit slip in ACTIVE, with the optional feature (SP_RESYNC_EN):
   - Stimulus: insert one extra bit, then BC×4.
   - With SP_RESYNC_EN: active drops in the cycle after the misaligned comma, relocks after 3 more commas, and the following 8'h55 gives 9'h155.
   - Without SP_RESYNC_EN: active stays 1 and shifted words are emitted with bit 8 = 1.
